l2_line_responder: RTL and testbench
====================================

# l2_line_responder

Memory-side responder for the cache arbiter's line protocol. It accepts one full-line read or write at a time from the arbiter, carries it out as a fixed-length burst of narrow beats on the physical-memory interface, and returns a single-cycle line response. It sits between the arbiter datapath's L2-facing port and the burst memory.

## Interface
- BEATS, 4, beats per line; counter width is $clog2(BEATS)
- BEAT_W, 64, bits per beat; line width LINE_W = BEATS*BEAT_W (256 by default)
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  reset; synchronous, active-low
- line_read  in  1  line read request; level, held until line_resp
- line_write  in  1  line write request; level, held until line_resp
- line_addr  in  32  byte address of the line; bits [4:0] ignored
- line_wdata  in  LINE_W  write line; beat k = bits [k*BEAT_W +: BEAT_W]
- line_rdata  out  LINE_W  assembled read line
- line_resp  out  1  one-cycle completion pulse
- burst_read  out  1  memory read burst request, level
- burst_write  out  1  memory write burst request, level
- burst_addr  out  32  line-aligned address, with bits [4:0] = 0
- burst_wdata  out  BEAT_W  current write beat
- burst_rdata  in  BEAT_W  current read beat, valid when burst_resp = 1
- burst_resp  in  1  one beat transferred this cycle

## Operation
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - line_read = 1 -> capture {line_addr[31:5], 5'b0} into addr_q, clear beat_cnt, go to RD_BURST.
  - Else line_write = 1 -> capture the address and line_wdata into wbuf, clear beat_cnt, go to WR_BURST.
  - If both are high, read wins. This is an illegal input; no error flag is raised.
- RD_BURST:
  - burst_read = 1 and burst_addr = addr_q for every cycle in the state.
  - On burst_resp: burst_rdata is written into line_rdata beat slot beat_cnt, and beat_cnt increments.
  - On the beat with beat_cnt = BEATS-1 -> go to DONE.
  - The counter is not wrapped or reused past BEATS-1.
- WR_BURST:
  - burst_write = 1 and burst_addr = addr_q.
  - burst_wdata = wbuf beat slot beat_cnt, driven combinationally from beat_cnt.
  - beat_cnt advances on burst_resp. The last beat -> DONE.
- DONE:
  - line_resp = 1 for exactly this cycle; burst_read and burst_write = 0.
  - Next state is always IDLE.
- line_rdata:
  - Is registered and holds its value until the next read burst overwrites it beat by beat.
  - Is valid in the DONE cycle and afterwards. A write does not modify it.
- Requester contract: drop line_read/line_write at the clock edge that ends the line_resp cycle. A request still high in the cycle after DONE is treated as a new request.
- A request dropped mid-burst does not abort the burst. The burst completes and line_resp still pulses once.
- Outputs in IDLE: burst_read = 0, burst_write = 0, line_resp = 0, burst_addr = addr_q.
- Reset (rst_n = 0 at any edge, including mid-burst):
  - State returns to IDLE.
  - beat_cnt, addr_q, wbuf, line_rdata, line_resp, burst_read and burst_write all go to 0.
  - No partial response is issued.

## Timing
- A request is sampled at the edge ending IDLE cycle t. burst_read or burst_write is high from cycle t+1.
- With burst_resp high every cycle, beats land in cycles t+1 … t+BEATS and line_resp is high in cycle t+BEATS+1. Minimum request-to-resp latency is BEATS+1 cycles (5 by default).
- Wait states (burst_resp = 0) stretch the burst cycle-for-cycle. Nothing times out.
- burst_resp while in IDLE or DONE is ignored.
- Back-to-back: the earliest next acceptance is the IDLE cycle immediately after DONE, so throughput is one line per BEATS+2 cycles.

## Test plan
- Read, zero wait:
  - Stimulus: line_read with line_addr = 0x0000_1234; burst_rdata beats = 0x11…11, 0x22…22, 0x33…33, 0x44…44 on consecutive cycles.
  - Required: burst_addr = 0x0000_1220; line_resp 5 cycles after the request; line_rdata = {0x44…,0x33…,0x22…,0x11…}.
- Write with waits:
  - Stimulus: line_write with line_wdata = 256'h…DDDD_CCCC_BBBB_AAAA pattern; burst_resp stalled 2 cycles before each beat.
  - Required: burst_wdata presents beat 0, 1, 2, 3 in order and each is held during its stall; line_resp occurs at cycle 13.
- Simultaneous line_read and line_write:
  - Required: burst_read only is asserted, and line_rdata updates.
- Back-to-back:
  - Stimulus: a read, then a write requested in the cycle after DONE.
  - Required: burst_write rises exactly 2 cycles after line_resp; two line_resp pulses in total.
- Reset mid-burst:
  - Stimulus: rst_n low after beat 2 of a read, then a new read.
  - Required: all outputs are 0 the cycle after reset; no line_resp; the new read completes normally with beat_cnt starting at 0.
- Request dropped mid-burst:
  - Stimulus: line_read deasserted after beat 1.
  - Required: the burst still completes 4 beats, and line_resp pulses once.

Source files
------------

// File: rtl/l2_line_responder.sv
// l2_line_responder: serves one full-line read or write at a time as a fixed burst of narrow memory beats
module l2_line_responder #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64,
    localparam int LINE_W = BEATS * BEAT_W,
    localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_addr,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic              burst_read,
    output logic              burst_write,
    output logic [31:0]       burst_addr,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
);
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;
    state_t                       state_q, state_d;
    logic [CW-1:0]                beat_cnt;
    logic [31:0]                  addr_q;
    logic [BEATS-1:0][BEAT_W-1:0] wbuf, rbuf;
    logic                         last_beat, accept, in_burst, addr_lsb_unused;
    assign last_beat       = beat_cnt == CW'(BEATS - 1);
    assign accept          = state_q == IDLE && (line_read || line_write);
    assign in_burst        = state_q == RD_BURST || state_q == WR_BURST;
    assign burst_addr      = addr_q;
    assign burst_wdata     = wbuf[beat_cnt];
    assign line_rdata      = rbuf;
    assign addr_lsb_unused = ^line_addr[4:0];
    always_comb begin
        state_d     = state_q;
        burst_read  = 1'b0;
        burst_write = 1'b0;
        line_resp   = 1'b0;
        case (state_q)
            IDLE: state_d = line_read ? RD_BURST : line_write ? WR_BURST : IDLE;
            RD_BURST: begin
                burst_read = 1'b1;
                state_d    = (burst_resp && last_beat) ? DONE : RD_BURST;
            end
            WR_BURST: begin
                burst_write = 1'b1;
                state_d     = (burst_resp && last_beat) ? DONE : WR_BURST;
            end
            default: begin
                line_resp = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end
    // read wins a simultaneous request, so the write buffer is only loaded for a pure write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_cnt <= '0;
            addr_q   <= '0;
            wbuf     <= '0;
            rbuf     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= {line_addr[31:5], 5'b0};
                beat_cnt <= '0;
            end
            if (accept && !line_read) wbuf <= line_wdata;
            if (in_burst && burst_resp && !last_beat) beat_cnt <= beat_cnt + 1'b1;
            if (state_q == RD_BURST && burst_resp) rbuf[beat_cnt] <= burst_rdata;
        end
    end
endmodule

// File: tb/tb_l2_line_responder.sv
// tb_l2_line_responder: directed line traffic against a beat-level memory model with a response scoreboard
module tb_l2_line_responder;
    logic         clk = 1'b0;
    logic         rst_n, line_read, line_write, line_resp, burst_read, burst_write, burst_resp;
    logic [31:0]  line_addr, burst_addr;
    logic [255:0] line_wdata, line_rdata;
    logic [63:0]  burst_wdata, burst_rdata;
    typedef struct {
        int           cyc;
        logic [255:0] rdata;
    } exp_t;
    exp_t         sb[$];
    int           errors = 0, checks = 0, resp_cnt = 0, cyc = 0;
    int           stall, mem_idx, mem_scnt, r0, d, n;
    logic [63:0]  rbeat[4];
    logic [63:0]  wbeat[4];
    logic [31:0]  exp_addr;
    logic [255:0] last_rdata = '0;
    logic [255:0] wd;
    exp_t         e;

    l2_line_responder dut (
        .clk(clk), .rst_n(rst_n), .line_read(line_read), .line_write(line_write),
        .line_addr(line_addr), .line_wdata(line_wdata), .line_rdata(line_rdata),
        .line_resp(line_resp), .burst_read(burst_read), .burst_write(burst_write),
        .burst_addr(burst_addr), .burst_wdata(burst_wdata), .burst_rdata(burst_rdata),
        .burst_resp(burst_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic set_rbeats(input logic [63:0] b0, b1, b2, b3);
        rbeat[0] = b0; rbeat[1] = b1; rbeat[2] = b2; rbeat[3] = b3;
    endtask

    // lag = idle cycles before the DUT can sample the request (1 when issued during DONE)
    task automatic request(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] wdat,
                           input int st, input int lag);
        exp_t x;
        stall    = st;
        exp_addr = {a[31:5], 5'b0};
        for (int k = 0; k < 4; k++) wbeat[k] = wdat[k*64 +: 64];
        if (rd) last_rdata = {rbeat[3], rbeat[2], rbeat[1], rbeat[0]};
        x.cyc   = cyc + lag + 5 + 4 * st;
        x.rdata = last_rdata;
        sb.push_back(x);
        line_read  = rd;
        line_write = wr;
        line_addr  = a;
        line_wdata = wdat;
    endtask

    task automatic wait_resp();
        int k = 0;
        while (line_resp !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k == 100) fail("resp_timeout");
        line_read  = 1'b0;
        line_write = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; line_read = 1'b0; line_write = 1'b0; line_addr = '0; line_wdata = '0;
        burst_resp = 1'b0; burst_rdata = '0; stall = 0; exp_addr = '0; mem_idx = 0; mem_scnt = 0;
        set_rbeats('0, '0, '0, '0);
        for (int k = 0; k < 4; k++) wbeat[k] = '0;
        fork
            begin
                repeat (3) @(negedge clk);
                chk("rst_line_resp", line_resp, 0);
                chk("rst_burst_read", burst_read, 0);
                chk("rst_burst_write", burst_write, 0);
                chk("rst_burst_addr", burst_addr, 0);
                chk("rst_line_rdata", line_rdata, 0);
                rst_n = 1'b1;
                @(negedge clk);
                // read, zero wait
                set_rbeats({16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});
                request(1, 0, 32'h0000_1234, '0, 0, 0);
                @(negedge clk);
                chk("rd_burst_read", burst_read, 1);
                chk("rd_burst_addr", burst_addr, 32'h0000_1220);
                wait_resp();
                chk("rd_line_rdata", line_rdata, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
                @(negedge clk);
                // write, two stall cycles before each beat
                wd = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
                request(0, 1, 32'h0000_8010, wd, 2, 0);
                @(negedge clk);
                chk("wr_burst_write", burst_write, 1);
                chk("wr_beat0", burst_wdata, 64'hAAAA_AAAA_AAAA_AAAA);
                wait_resp();
                @(negedge clk);
                // simultaneous read and write: read wins
                set_rbeats({16{4'h5}}, {16{4'h6}}, {16{4'h7}}, {16{4'h8}});
                request(1, 1, 32'h0000_4040, wd, 0, 0);
                @(negedge clk);
                chk("both_burst_read", burst_read, 1);
                chk("both_burst_write", burst_write, 0);
                wait_resp();
                @(negedge clk);
                // back-to-back read then write
                r0 = resp_cnt;
                set_rbeats(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_F0F0_F0F0, 64'hDEAD_BEEF_CAFE_F00D);
                request(1, 0, 32'h0000_6000, '0, 0, 0);
                wait_resp();
                d = cyc;
                request(0, 1, 32'h0000_7020, ~wd, 0, 1);
                n = 0;
                while (burst_write !== 1'b1 && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                chk("b2b_gap", cyc - d, 2);
                wait_resp();
                @(negedge clk);
                chk("b2b_resp_count", resp_cnt - r0, 2);
                // reset in the middle of a read
                r0 = resp_cnt;
                set_rbeats({16{4'h9}}, {16{4'hA}}, {16{4'hB}}, {16{4'hC}});
                stall = 0;
                exp_addr = 32'h0000_3000;
                line_addr = 32'h0000_3000;
                line_read = 1'b1;
                repeat (3) @(negedge clk);
                rst_n = 1'b0;
                line_read = 1'b0;
                @(negedge clk);
                chk("mrst_line_resp", line_resp, 0);
                chk("mrst_burst_read", burst_read, 0);
                chk("mrst_burst_write", burst_write, 0);
                chk("mrst_burst_addr", burst_addr, 0);
                chk("mrst_burst_wdata", burst_wdata, 0);
                chk("mrst_line_rdata", line_rdata, 0);
                rst_n = 1'b1;
                last_rdata = '0;
                repeat (3) @(negedge clk);
                chk("no_partial_resp", resp_cnt, r0);
                set_rbeats(64'h1000_0000_0000_0001, 64'h2000_0000_0000_0002, 64'h3000_0000_0000_0003, 64'h4000_0000_0000_0004);
                request(1, 0, 32'h0000_3000, '0, 0, 0);
                wait_resp();
                @(negedge clk);
                // request dropped mid-burst
                r0 = resp_cnt;
                set_rbeats(64'h5555_0000_0000_1111, 64'h6666_0000_0000_2222, 64'h7777_0000_0000_3333, 64'h8888_0000_0000_4444);
                request(1, 0, 32'h0000_5000, '0, 0, 0);
                repeat (2) @(negedge clk);
                line_read = 1'b0;
                wait_resp();
                repeat (3) @(negedge clk);
                chk("drop_resp_count", resp_cnt - r0, 1);
                chk("drop_idle_after", burst_read, 0);
                chk("sb_drained", sb.size(), 0);
            end
            forever begin
                @(negedge clk);
                if (line_resp === 1'b1) begin
                    resp_cnt++;
                    if (sb.size() == 0) fail("unexpected_resp");
                    else begin
                        e = sb.pop_front();
                        chk("resp_cycle", cyc, e.cyc);
                        chk("line_rdata", line_rdata, e.rdata);
                    end
                end
            end
            forever begin
                @(negedge clk);
                if (burst_read || burst_write) begin
                    chk("burst_addr", burst_addr, exp_addr);
                    if (burst_read && burst_write) fail("both_bursts");
                    if (mem_idx >= 4) begin
                        fail("extra_beat");
                        burst_resp = 1'b0;
                    end else begin
                        if (burst_write) chk("burst_wdata", burst_wdata, wbeat[mem_idx]);
                        if (mem_scnt < stall) begin
                            burst_resp = 1'b0;
                            mem_scnt++;
                        end else begin
                            burst_resp  = 1'b1;
                            burst_rdata = rbeat[mem_idx];
                            mem_scnt = 0;
                            mem_idx++;
                        end
                    end
                end else begin
                    burst_resp = 1'b0;
                    mem_idx = 0;
                    mem_scnt = 0;
                end
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
